// File: rtl/display_pkg.sv
// Shared types and default timing for the multiplexed display scan logic.
// Defaults assume a 25 MHz clock: 83333 cycles per digit slot, 250 cycles of anti-ghost blanking.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam int DEFAULT_CYCLES_PER_DIGIT = 83333;
    localparam int DEFAULT_BLANK_CYCLES     = 250;

endpackage

// File: rtl/next_enabled_digit.sv
// Wrap-around priority search: first set mask bit strictly after start_idx, wrapping to start_idx itself last.
// Latency: combinational. Backpressure: none.
// wrapped flags a result at or below start_idx; none flags an all-zero mask.
module next_enabled_digit
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 5
) (
    input  logic [NUM_DIGITS-1:0]         mask,
    input  logic [$clog2(NUM_DIGITS)-1:0] start_idx,
    output logic [$clog2(NUM_DIGITS)-1:0] next_idx,
    output logic                          wrapped,
    output logic                          none
);

    localparam int IW = $clog2(NUM_DIGITS);

    // One extra bit so start_idx + k (at most 2*NUM_DIGITS-1) never overflows before the wrap.
    logic [IW:0] pos;

    always_comb begin
        next_idx = start_idx;
        none     = 1'b1;
        pos      = '0;
        // Descending scan so the nearest candidate after start_idx is the last one to win.
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            pos = {1'b0, start_idx} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_DIGITS)) begin
                pos = pos - (IW+1)'(NUM_DIGITS);
            end
            if (mask[pos[IW-1:0]]) begin
                next_idx = pos[IW-1:0];
                none     = 1'b0;
            end
        end
        wrapped = !none && (next_idx <= start_idx);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner: one-hot select per slot, leading blanking, runtime digit mask, frame strobe.
// Latency: all outputs registered; en edge to select change is 1 cycle.
// Backpressure: none; digit_mask is sampled only on leaving IDLE and at slot boundaries.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 5,
    parameter int CYCLES_PER_DIGIT = DEFAULT_CYCLES_PER_DIGIT,
    parameter int BLANK_CYCLES     = DEFAULT_BLANK_CYCLES,
    parameter int SEL_ACTIVE_LOW   = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          blank,
    output logic                          frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(CYCLES_PER_DIGIT);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLES_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam scan_state_t   SLOT_FIRST = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF =
        (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    scan_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_d;
    logic [NUM_DIGITS-1:0] sel_d;
    logic                  fs_d;

    logic [IW-1:0]         search_start;
    logic [IW-1:0]         search_idx;
    logic                  search_wrapped;
    logic                  search_none;

    // From IDLE, starting at the top index makes the wrap-around search return the lowest set bit.
    assign search_start = (state_q == ST_IDLE) ? IW'(NUM_DIGITS - 1) : digit_idx;

    next_enabled_digit #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_search (
        .mask      (digit_mask),
        .start_idx (search_start),
        .next_idx  (search_idx),
        .wrapped   (search_wrapped),
        .none      (search_none)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = digit_idx;
        fs_d    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!search_none) begin
                        state_d = SLOT_FIRST;
                        idx_d   = search_idx;
                        fs_d    = 1'b1;
                    end
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (search_none) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = SLOT_FIRST;
                            idx_d   = search_idx;
                            fs_d    = search_wrapped;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sel_d = SEL_OFF;
        if (state_d == ST_ON) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sel_d[i] = (idx_d == IW'(i)) ^ SEL_OFF[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            digit_idx   <= '0;
            digit_sel   <= SEL_OFF;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_idx   <= idx_d;
            digit_sel   <= sel_d;
            blank       <= (state_d != ST_ON);
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: 5 digits, 10-cycle slots, 2 blank cycles; a second instance covers active-low select with no blanking.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, en;
    logic [4:0] digit_mask;
    logic [2:0] digit_idx;
    logic [4:0] digit_sel;
    logic       blank, frame_start;

    logic       b_reset_n, b_en;
    logic [4:0] b_digit_mask;
    logic [2:0] b_digit_idx;
    logic [4:0] b_digit_sel;
    logic       b_blank, b_frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    display_scan_ctrl #(
        .NUM_DIGITS(5), .CYCLES_PER_DIGIT(10), .BLANK_CYCLES(2), .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_mask(digit_mask),
        .digit_idx(digit_idx), .digit_sel(digit_sel), .blank(blank), .frame_start(frame_start)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(5), .CYCLES_PER_DIGIT(10), .BLANK_CYCLES(0), .SEL_ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .reset_n(b_reset_n), .en(b_en), .digit_mask(b_digit_mask),
        .digit_idx(b_digit_idx), .digit_sel(b_digit_sel), .blank(b_blank), .frame_start(b_frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got, exp;
        reset_n = 1'b0; en = 1'b1; digit_mask = 5'b11111;
        repeat (2) step();
        n_cmp++; if (digit_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
        n_cmp++; if (digit_sel !== 5'b00000) begin n_bad++; $display("FAIL reset_sel got=%b exp=00000", digit_sel); end
        n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("FAIL reset_blank got=%b exp=1", blank); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        reset_n = 1'b1;
        // Still IDLE until the first edge after release.
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00000, 1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL idle_cycle idx|sel|blank|fs got=%b exp=%b", got, exp); end
        step();
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00000, 1'b1, 1'b1};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL first_frame_start idx|sel|blank|fs got=%b exp=%b", got, exp); end
        step();
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00000, 1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL second_blank idx|sel|blank|fs got=%b exp=%b", got, exp); end
        for (int i = 0; i < 8; i++) begin
            step();
            got = {digit_idx, digit_sel, blank, frame_start};
            exp = {3'd0, 5'b00001, 1'b0, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL slot0_on c=%0d idx|sel|blank|fs got=%b exp=%b", i + 2, got, exp); end
        end
    endtask

    task automatic test_full_scan();
        logic [9:0] got, exp;
        logic [4:0] one, e_sel;
        logic [2:0] e_idx;
        logic       e_blank, e_fs;
        one = 5'b00001;
        for (int t = 0; t < 50; t++) begin
            step();
            e_idx   = 3'((1 + t / 10) % 5);
            e_blank = (t % 10) < 2;
            e_sel   = e_blank ? 5'b00000 : (one << e_idx);
            e_fs    = (t == 40);
            got = {digit_idx, digit_sel, blank, frame_start};
            exp = {e_idx, e_sel, e_blank, e_fs};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL full_scan t=%0d idx|sel|blank|fs got=%b exp=%b", t, got, exp); end
            if (!blank) begin
                n_cmp++; if ($countones(digit_sel) != 1) begin n_bad++; $display("FAIL onehot t=%0d sel=%b exp one bit", t, digit_sel); end
            end
        end
    endtask

    task automatic test_sparse_mask();
        int         seq [10] = '{2, 4, 0, 2, 4, 0, 2, 1, 1, 1};
        logic [9:0] got, exp;
        logic [4:0] one, e_sel;
        logic [2:0] e_idx;
        logic       e_blank, e_fs;
        int         s;
        one = 5'b00001;
        digit_mask = 5'b10101;
        for (int t = 0; t < 100; t++) begin
            step();
            s       = t / 10;
            e_idx   = 3'(seq[s]);
            e_blank = (t % 10) < 2;
            e_sel   = e_blank ? 5'b00000 : (one << e_idx);
            e_fs    = ((t % 10) == 0) && (s == 2 || s == 5 || s >= 7);
            got = {digit_idx, digit_sel, blank, frame_start};
            exp = {e_idx, e_sel, e_blank, e_fs};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sparse_mask t=%0d idx|sel|blank|fs got=%b exp=%b", t, got, exp); end
            if (t == 65) digit_mask = 5'b00010;
        end
    endtask

    task automatic test_mask_zero();
        logic [9:0] got, exp;
        digit_mask = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            step();
            got = {digit_idx, digit_sel, blank, frame_start};
            exp = {3'd1, 5'b00000, 1'b1, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask_zero_idle i=%0d idx|sel|blank|fs got=%b exp=%b", i, got, exp); end
        end
        digit_mask = 5'b01000;
        for (int t = 0; t < 11; t++) begin
            step();
            exp = {3'd3, ((t % 10) < 2) ? 5'b00000 : 5'b01000, (t % 10) < 2, (t % 10) == 0};
            got = {digit_idx, digit_sel, blank, frame_start};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask_resume t=%0d idx|sel|blank|fs got=%b exp=%b", t, got, exp); end
        end
    endtask

    task automatic test_en_drop();
        logic [9:0] got, exp;
        // Continue the digit-3 slot started at the end of the previous task (slot cycles 1..5).
        for (int c = 1; c <= 5; c++) begin
            step();
            exp = {3'd3, (c < 2) ? 5'b00000 : 5'b01000, c < 2, 1'b0};
            got = {digit_idx, digit_sel, blank, frame_start};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL pre_drop c=%0d idx|sel|blank|fs got=%b exp=%b", c, got, exp); end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {digit_idx, digit_sel, blank, frame_start};
            exp = {3'd3, 5'b00000, 1'b1, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL en_low i=%0d idx|sel|blank|fs got=%b exp=%b", i, got, exp); end
        end
        en = 1'b1; digit_mask = 5'b11111;
        step();
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00000, 1'b1, 1'b1};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL restart_fs idx|sel|blank|fs got=%b exp=%b", got, exp); end
        step();
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00000, 1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL restart_blank2 idx|sel|blank|fs got=%b exp=%b", got, exp); end
        step();
        got = {digit_idx, digit_sel, blank, frame_start};
        exp = {3'd0, 5'b00001, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL restart_on idx|sel|blank|fs got=%b exp=%b", got, exp); end
    endtask

    task automatic test_active_low_no_blank();
        logic [9:0] got, exp;
        logic [4:0] one, e_sel;
        logic [2:0] e_idx;
        one = 5'b00001;
        got = {b_digit_idx, b_digit_sel, b_blank, b_frame_start};
        exp = {3'd0, 5'b11111, 1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b_reset idx|sel|blank|fs got=%b exp=%b", got, exp); end
        b_reset_n = 1'b1;
        step();
        for (int t = 0; t < 13; t++) begin
            if (t > 0) step();
            e_idx = 3'(t / 10);
            e_sel = ~(one << e_idx);
            exp = {e_idx, e_sel, 1'b0, t == 0};
            got = {b_digit_idx, b_digit_sel, b_blank, b_frame_start};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b_scan t=%0d idx|sel|blank|fs got=%b exp=%b", t, got, exp); end
        end
        b_reset_n = 1'b0;
        #1;
        got = {b_digit_idx, b_digit_sel, b_blank, b_frame_start};
        exp = {3'd0, 5'b11111, 1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b_async_reset idx|sel|blank|fs got=%b exp=%b", got, exp); end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; digit_mask = 5'b11111;
        b_reset_n = 1'b0; b_en = 1'b1; b_digit_mask = 5'b11111;
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_mask_zero();
        test_en_drop();
        test_active_low_no_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
